dvp_cam_emulator: RTL

- Transmit end of the 8-bit parallel camera (DVP) interface that the capture path receives: cam_vsync, cam_href, cam_pclk, cam_data[7:0].
- Generates OV7670-style RGB565 frames from internal test patterns.
- Lets the capture logic, frame buffer and VGA path be brought up and regression-tested without a sensor on GPIO_0.
- Sits in the FPGA fabric, muxed ahead of the capture block's camera inputs.

---
 rtl/dvp_pkg.sv | 47 ++++
 rtl/dvp_cam_emulator_pixel_gen.sv | 59 +++++
 rtl/dvp_cam_emulator.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP camera emulator: FSM states,
// test-pattern selectors and the RGB565 colour-bar palette.
package dvp_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_SOLID = 2'd2,
    PAT_COUNT = 2'd3
  } pattern_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } state_e;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  // Bar index 0 is the leftmost bar.
  function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dvp_cam_emulator_pixel_gen.sv
// Registered pixel-byte lookup: turns (x, byte half, pattern) into the
// next cam_data byte one clk ahead of the slot edge that presents it.
module dvp_pixel_gen
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int XW       = $clog2(H_ACTIVE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [XW-1:0] x,
  input  logic          lo,
  input  pattern_e      pattern,
  input  logic [15:0]   solid,
  input  logic [7:0]    count,
  output logic [7:0]    data
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [6:0]  past_edge;
  logic [2:0]  bar_idx;
  logic [7:0]  g;
  logic [15:0] pixel;
  logic [7:0]  byte_next;

  // Thermometer of bar boundaries avoids dividing x by a non-power-of-2 width.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_bar_edge
      assign past_edge[gi] = (int'(x) >= (gi + 1) * BAR_W);
    end
  endgenerate

  always_comb begin
    bar_idx = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (past_edge[i]) bar_idx = 3'(i + 1);
    end
  end

  assign g = 8'(x);

  always_comb begin
    pixel = solid;
    case (pattern)
      PAT_BARS: pixel = bar_rgb(bar_idx);
      PAT_RAMP: pixel = {g[7:3], g[7:2], g[7:3]};
      default:  pixel = solid;
    endcase
    byte_next = lo ? pixel[7:0] : pixel[15:8];
    if (pattern == PAT_COUNT) byte_next = count;
  end

  always_ff @(posedge clk) begin
    if (reset) data <= 8'h00;
    else       data <= byte_next;
  end

endmodule

// File: rtl/dvp_cam_emulator.sv
// OV7670-style DVP transmitter: emits RGB565 test-pattern frames on
// cam_pclk/cam_vsync/cam_href/cam_data with pclk = clk/2.
module dvp_cam_emulator
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 288,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  output logic        cam_pclk,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic        busy
);

  localparam int ACTIVE_BYTES = 2 * H_ACTIVE;
  localparam int LINE_BYTES   = ACTIVE_BYTES + H_BLANK;
  localparam int BW           = $clog2(LINE_BYTES);
  localparam int MAX_LINES    = max_int(max_int(VSYNC_LINES, V_BACK), max_int(V_ACTIVE, V_FRONT));
  localparam int LW           = $clog2(MAX_LINES + 1);
  localparam int XW           = $clog2(H_ACTIVE);

  state_e          state_reg, state_next;
  logic [BW-1:0]   byte_reg, byte_next;
  logic [LW-1:0]   line_reg, line_next, last_line;
  logic            frame_end;
  logic            slot_edge;
  logic            href_next;
  logic [7:0]      count_reg;
  pattern_e        pattern_reg;
  logic [15:0]     solid_reg;
  logic [7:0]      pixel_byte;

  // Counters describe the slot currently on the pins; *_next is the slot
  // that will be presented at the next pclk-falling edge.
  assign slot_edge = (state_reg == IDLE) || cam_pclk;
  assign busy      = (state_reg != IDLE);

  always_comb begin
    case (state_reg)
      VSYNC:   last_line = LW'(VSYNC_LINES - 1);
      VBACK:   last_line = LW'(V_BACK - 1);
      ACTIVE:  last_line = LW'(V_ACTIVE - 1);
      default: last_line = LW'(V_FRONT - 1);
    endcase
  end

  always_comb begin
    state_next = state_reg;
    byte_next  = byte_reg;
    line_next  = line_reg;
    frame_end  = 1'b0;
    if (state_reg == IDLE) begin
      byte_next = '0;
      line_next = '0;
      if (enable) state_next = VSYNC;
    end else if (byte_reg == BW'(LINE_BYTES - 1)) begin
      byte_next = '0;
      if (line_reg == last_line) begin
        line_next = '0;
        case (state_reg)
          VSYNC:  state_next = VBACK;
          VBACK:  state_next = ACTIVE;
          ACTIVE: state_next = VFRONT;
          default: begin
            frame_end  = 1'b1;
            state_next = enable ? VSYNC : IDLE;
          end
        endcase
      end else begin
        line_next = line_reg + LW'(1);
      end
    end else begin
      byte_next = byte_reg + BW'(1);
    end
  end

  assign href_next = (state_next == ACTIVE) && (byte_next < BW'(ACTIVE_BYTES));

  dvp_pixel_gen #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (XW)
  ) u_pixel_gen (
    .clk     (clk),
    .reset   (reset),
    .x       (XW'(byte_next >> 1)),
    .lo      (byte_next[0]),
    .pattern (pattern_reg),
    .solid   (solid_reg),
    .count   (count_reg),
    .data    (pixel_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      byte_reg    <= '0;
      line_reg    <= '0;
      cam_pclk    <= 1'b0;
      cam_vsync   <= 1'b0;
      cam_href    <= 1'b0;
      cam_data    <= 8'h00;
      frame_done  <= 1'b0;
      count_reg   <= 8'h00;
      pattern_reg <= PAT_BARS;
      solid_reg   <= 16'h0000;
    end else begin
      cam_pclk   <= (state_reg == IDLE) ? 1'b0 : ~cam_pclk;
      frame_done <= 1'b0;
      if (slot_edge) begin
        state_reg  <= state_next;
        byte_reg   <= byte_next;
        line_reg   <= line_next;
        cam_vsync  <= (state_next == VSYNC);
        cam_href   <= href_next;
        cam_data   <= href_next ? pixel_byte : 8'h00;
        frame_done <= frame_end;
        // Frame start: pattern is frozen for the whole frame.
        if (state_next == VSYNC && state_reg != VSYNC) begin
          pattern_reg <= pattern_e'(pattern_sel);
          solid_reg   <= solid_rgb;
          count_reg   <= 8'h00;
        end else if (href_next) begin
          count_reg <= count_reg + 8'h01;
        end
      end
    end
  end

endmodule
